// File: rtl/button_event.sv
// rtl/button_event.sv - debounced button level to press/release/long-press/repeat strobes
// Hold time is counted in ms_16 ticks; every output is registered.
module button_event #(
  parameter int LONG_TICKS   = 32,
  parameter int REPEAT_TICKS = 8,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic ms_16,
  input  logic btn,
  output logic press,
  output logic release_p,
  output logic long_press,
  output logic repeat_p,
  output logic held
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    LONG = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;
  logic             release_q;
  logic             long_q;
  logic             repeat_q;
  logic             held_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      case (state_q)
        // Leave IDLE on the level, so a button held through reset still yields a press.
        IDLE: begin
          if (btn) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            press_q <= 1'b1;
            held_q  <= 1'b1;
          end else begin
            held_q  <= 1'b0;
          end
        end
        HOLD: begin
          if (!btn) begin
            state_q   <= IDLE;
            release_q <= 1'b1;
            held_q    <= 1'b0;
          end else begin
            held_q <= 1'b1;
            if (ms_16) begin
              if (cnt_q == LONG_LAST) begin
                state_q <= LONG;
                cnt_q   <= '0;
                long_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end
          end
        end
        LONG: begin
          if (!btn) begin
            state_q   <= IDLE;
            release_q <= 1'b1;
            held_q    <= 1'b0;
          end else begin
            held_q <= 1'b1;
            if (ms_16) begin
              if (cnt_q == REPEAT_LAST) begin
                cnt_q    <= '0;
                repeat_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign press      = press_q;
  assign release_p  = release_q;
  assign long_press = long_q;
  assign repeat_p   = repeat_q;
  assign held       = held_q;

endmodule
